// File: rtl/hazard_ctrl.sv
// Hazard-control unit: load-use/RAW stall FSM, branch squash, EX operand forwarding selects and a
// saturating stall-cycle counter. Define HAZARD_FWD_EN to enable forwarding; otherwise RAW stalls.
module hazard_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   ifid_instr,
    input  logic              idex_mem_read,
    input  logic              idex_reg_write,
    input  logic [RA_W-1:0]   idex_rd,
    input  logic [RA_W-1:0]   idex_rs1,
    input  logic [RA_W-1:0]   idex_rs2,
    input  logic              exmem_reg_write,
    input  logic [RA_W-1:0]   exmem_rd,
    input  logic              memwb_reg_write,
    input  logic [RA_W-1:0]   memwb_rd,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_active,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    localparam logic [2:0] CntInit = 3'(LOAD_LAT - 1);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_cycles_q;

    logic [6:0]      opcode;
    logic [RA_W-1:0] rs1, rs2;
    logic            use_rs1, use_rs2;
    logic            load_hit, raw_hit, stall;
    logic            unused_bits;

    assign opcode      = ifid_instr[6:0];
    assign rs1         = RA_W'(ifid_instr[19:15]);
    assign rs2         = RA_W'(ifid_instr[24:20]);
    assign unused_bits = ^{ifid_instr[XLEN-1:25], ifid_instr[14:7]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    // True when a non-x0 destination feeds a source the IF/ID instruction actually reads.
    function automatic logic src_hit(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] s1,
                                     input logic u1, input logic [RA_W-1:0] s2, input logic u2);
        return (rd != '0) && ((u1 && (rd == s1)) || (u2 && (rd == s2)));
    endfunction

    assign load_hit = idex_mem_read && idex_reg_write &&
                      src_hit(idex_rd, rs1, use_rs1, rs2, use_rs2);

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs);
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
            return 2'b10;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign raw_hit = 1'b0;
    assign fwd_a   = fwd_sel(idex_rs1);
    assign fwd_b   = fwd_sel(idex_rs2);
`else
    logic unused_fwd;

    assign raw_hit = (idex_reg_write && src_hit(idex_rd, rs1, use_rs1, rs2, use_rs2)) ||
                     (exmem_reg_write && src_hit(exmem_rd, rs1, use_rs1, rs2, use_rs2));
    assign fwd_a      = 2'b00;
    assign fwd_b      = 2'b00;
    assign unused_fwd = ^{idex_rs1, idex_rs2, memwb_reg_write, memwb_rd};
`endif

    // A taken branch overrides any stall: the stalled instruction is squashed anyway.
    assign stall = !ex_branch_taken && ((state_q == StStall) || load_hit || raw_hit);

    always_comb begin
        pc_write     = !stall;
        ifid_write   = !stall;
        idex_bubble  = stall || ex_branch_taken;
        ifid_flush   = ex_branch_taken;
        stall_active = (state_q == StStall);
        stall_cycles = stall_cycles_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ex_branch_taken) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load_hit && (LOAD_LAT > 1)) begin
                        state_d = StStall;
                        cnt_d   = CntInit;
                    end
                end
                StStall: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= 3'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_write && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a LOAD_LAT=1 instance (3-bit counter) and a LOAD_LAT=3
// instance share stimulus; table vectors check combinational outputs, sequences check the FSM.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ifid_instr;
    logic        idex_mem_read, idex_reg_write, exmem_reg_write, memwb_reg_write;
    logic [4:0]  idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
    logic        ex_branch_taken;

    logic        pw1, iw1, bub1, fl1, sa1;
    logic [1:0]  fa1, fb1;
    logic [2:0]  sc1;
    logic        pw3, iw3, bub3, fl3, sa3;
    logic [1:0]  fa3, fb3;
    logic [31:0] sc3;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .PERF_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pw1), .ifid_write(iw1), .idex_bubble(bub1), .ifid_flush(fl1),
        .fwd_a(fa1), .fwd_b(fb1), .stall_active(sa1), .stall_cycles(sc1)
    );

    hazard_ctrl #(.LOAD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr),
        .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write), .idex_rd(idex_rd),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .ex_branch_taken(ex_branch_taken),
        .pc_write(pw3), .ifid_write(iw3), .idex_bubble(bub3), .ifid_flush(fl3),
        .fwd_a(fa3), .fwd_b(fb3), .stall_active(sa3), .stall_cycles(sc3)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] s1, input logic [4:0] s2);
        return {7'b0, s2, s1, 3'b000, rd, op};
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic        mr, rw;
        logic [4:0]  rd, rs1, rs2;
        logic        ew;
        logic [4:0]  erd;
        logic        mw;
        logic [4:0]  mrd;
        logic        br;
        logic        pw, bub, fl;
        logic [1:0]  fa, fb;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] instr, input logic mr, input logic rw,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic ew, input logic [4:0] erd,
                                input logic mw, input logic [4:0] mrd, input logic br,
                                input logic pw, input logic bub, input logic fl,
                                input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.instr = instr; v.mr = mr; v.rw = rw; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.ew = ew; v.erd = erd; v.mw = mw; v.mrd = mrd; v.br = br;
        v.pw = pw; v.bub = bub; v.fl = fl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic idle_inputs();
        ifid_instr = 32'h0000_0013;
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_rd = 5'd0;
        idex_rs1 = 5'd0; idex_rs2 = 5'd0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0;
        ex_branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // lw x5 in EX, add x6,x5,x7 in IF/ID
    task automatic load_use();
        ifid_instr = enc(7'b0110011, 5'd6, 5'd5, 5'd7);
        idex_mem_read = 1'b1; idex_reg_write = 1'b1; idex_rd = 5'd5;
    endtask

    task automatic bubble_ex();
        idex_mem_read = 1'b0; idex_reg_write = 1'b0; idex_rd = 5'd0;
    endtask

    vec_t vecs[20];

    initial begin
        logic [31:0] nop, add657, add675, sw, add600, lui5, addi685, jalr, sub211, beq, sys;
        logic [1:0]  f10, f01;
        logic        ns;
        nop     = 32'h0000_0013;
        add657  = enc(7'b0110011, 5'd6, 5'd5, 5'd7);
        add675  = enc(7'b0110011, 5'd6, 5'd7, 5'd5);
        sw      = enc(7'b0100011, 5'd0, 5'd8, 5'd5);
        add600  = enc(7'b0110011, 5'd6, 5'd0, 5'd0);
        lui5    = enc(7'b0110111, 5'd5, 5'd5, 5'd5);
        addi685 = enc(7'b0010011, 5'd6, 5'd8, 5'd5);
        jalr    = enc(7'b1100111, 5'd1, 5'd5, 5'd0);
        sub211  = enc(7'b0110011, 5'd2, 5'd1, 5'd1);
        beq     = enc(7'b1100011, 5'd0, 5'd9, 5'd4);
        sys     = enc(7'b1110011, 5'd5, 5'd5, 5'd5);
        f10 = FWD ? 2'b10 : 2'b00;
        f01 = FWD ? 2'b01 : 2'b00;
        ns  = !FWD;  // RAW on a non-load stalls only without forwarding

        //               instr    mr rw rd  rs1 rs2 ew erd mw mrd br  pw   bub  fl fa   fb
        vecs[0]  = mk(nop,     0, 0, 0,  0,  0,  0, 0,  0, 0,  0,  1,   0,   0, 0,   0);
        vecs[1]  = mk(add657,  1, 1, 5,  0,  0,  0, 0,  0, 0,  0,  0,   1,   0, 0,   0);
        vecs[2]  = mk(add675,  1, 1, 5,  0,  0,  0, 0,  0, 0,  0,  0,   1,   0, 0,   0);
        vecs[3]  = mk(sw,      1, 1, 5,  0,  0,  0, 0,  0, 0,  0,  0,   1,   0, 0,   0);
        vecs[4]  = mk(add600,  1, 1, 0,  0,  0,  0, 0,  0, 0,  0,  1,   0,   0, 0,   0);
        vecs[5]  = mk(lui5,    1, 1, 5,  0,  0,  0, 0,  0, 0,  0,  1,   0,   0, 0,   0);
        vecs[6]  = mk(addi685, 1, 1, 5,  0,  0,  0, 0,  0, 0,  0,  1,   0,   0, 0,   0);
        vecs[7]  = mk(jalr,    1, 1, 5,  0,  0,  0, 0,  0, 0,  0,  0,   1,   0, 0,   0);
        vecs[8]  = mk(add657,  1, 1, 5,  0,  0,  0, 0,  0, 0,  1,  1,   1,   1, 0,   0);
        vecs[9]  = mk(nop,     0, 0, 0,  3,  0,  1, 3,  1, 3,  0,  1,   0,   0, f10, 0);
        vecs[10] = mk(nop,     0, 0, 0,  3,  0,  0, 3,  1, 3,  0,  1,   0,   0, f01, 0);
        vecs[11] = mk(nop,     0, 0, 0,  0,  0,  1, 0,  1, 0,  0,  1,   0,   0, 0,   0);
        vecs[12] = mk(nop,     0, 0, 0,  9,  4,  1, 9,  1, 4,  0,  1,   0,   0, f10, f01);
        vecs[13] = mk(sub211,  0, 1, 1,  0,  0,  0, 0,  0, 0,  0,  !ns, ns,  0, 0,   0);
        vecs[14] = mk(sub211,  0, 0, 0,  0,  0,  1, 1,  0, 0,  0,  !ns, ns,  0, 0,   0);
        vecs[15] = mk(sub211,  0, 0, 0,  0,  0,  0, 0,  1, 1,  0,  1,   0,   0, 0,   0);
        vecs[16] = mk(add657,  1, 0, 5,  0,  0,  0, 0,  0, 0,  0,  1,   0,   0, 0,   0);
        vecs[17] = mk(beq,     0, 1, 4,  0,  0,  0, 0,  0, 0,  0,  !ns, ns,  0, 0,   0);
        vecs[18] = mk(sys,     1, 1, 5,  0,  0,  0, 0,  0, 0,  0,  1,   0,   0, 0,   0);
        vecs[19] = mk(nop,     0, 0, 0,  0,  3,  1, 3,  1, 3,  0,  1,   0,   0, 0,   f10);

        do_reset();
        #1;
        check("rst pc_write1", {31'd0, pw1}, 1);   check("rst pc_write3", {31'd0, pw3}, 1);
        check("rst ifid_write", {31'd0, iw1}, 1);  check("rst bubble", {31'd0, bub1}, 0);
        check("rst flush", {31'd0, fl1}, 0);       check("rst fwd_a", {30'd0, fa1}, 0);
        check("rst fwd_b", {30'd0, fb1}, 0);       check("rst stall_active", {31'd0, sa3}, 0);
        check("rst stall_cycles1", {29'd0, sc1}, 0); check("rst stall_cycles3", sc3, 0);

        // Inputs are applied mid-cycle and returned to idle before the next edge.
        for (int i = 0; i < 20; i++) begin
            tick();
            ifid_instr = vecs[i].instr;
            idex_mem_read = vecs[i].mr; idex_reg_write = vecs[i].rw; idex_rd = vecs[i].rd;
            idex_rs1 = vecs[i].rs1; idex_rs2 = vecs[i].rs2;
            exmem_reg_write = vecs[i].ew; exmem_rd = vecs[i].erd;
            memwb_reg_write = vecs[i].mw; memwb_rd = vecs[i].mrd;
            ex_branch_taken = vecs[i].br;
            #1;
            check($sformatf("v%0d pc_write1", i), {31'd0, pw1}, {31'd0, vecs[i].pw});
            check($sformatf("v%0d ifid_write1", i), {31'd0, iw1}, {31'd0, vecs[i].pw});
            check($sformatf("v%0d bubble1", i), {31'd0, bub1}, {31'd0, vecs[i].bub});
            check($sformatf("v%0d flush1", i), {31'd0, fl1}, {31'd0, vecs[i].fl});
            check($sformatf("v%0d fwd_a1", i), {30'd0, fa1}, {30'd0, vecs[i].fa});
            check($sformatf("v%0d fwd_b1", i), {30'd0, fb1}, {30'd0, vecs[i].fb});
            check($sformatf("v%0d pc_write3", i), {31'd0, pw3}, {31'd0, vecs[i].pw});
            check($sformatf("v%0d ifid_write3", i), {31'd0, iw3}, {31'd0, vecs[i].pw});
            check($sformatf("v%0d bubble3", i), {31'd0, bub3}, {31'd0, vecs[i].bub});
            check($sformatf("v%0d flush3", i), {31'd0, fl3}, {31'd0, vecs[i].fl});
            check($sformatf("v%0d fwd_a3", i), {30'd0, fa3}, {30'd0, vecs[i].fa});
            check($sformatf("v%0d fwd_b3", i), {30'd0, fb3}, {30'd0, vecs[i].fb});
            idle_inputs();
        end

        // LOAD_LAT=1: single stall cycle
        do_reset();
        load_use(); #1;
        check("ll1 c1 pc_write", {31'd0, pw1}, 0);
        check("ll1 c1 bubble", {31'd0, bub1}, 1);
        check("ll1 c1 stall_active", {31'd0, sa1}, 0);
        tick(); bubble_ex(); #1;
        check("ll1 c2 pc_write", {31'd0, pw1}, 1);
        check("ll1 stall_cycles", {29'd0, sc1}, 1);

        // LOAD_LAT=3: three stall cycles, STALL state in cycles 2-3
        do_reset();
        load_use(); #1;
        check("ll3 c1 pc_write", {31'd0, pw3}, 0);
        check("ll3 c1 stall_active", {31'd0, sa3}, 0);
        tick(); bubble_ex(); #1;
        check("ll3 c2 pc_write", {31'd0, pw3}, 0);
        check("ll3 c2 bubble", {31'd0, bub3}, 1);
        check("ll3 c2 stall_active", {31'd0, sa3}, 1);
        tick(); #1;
        check("ll3 c3 pc_write", {31'd0, pw3}, 0);
        check("ll3 c3 stall_active", {31'd0, sa3}, 1);
        tick(); #1;
        check("ll3 c4 pc_write", {31'd0, pw3}, 1);
        check("ll3 c4 stall_active", {31'd0, sa3}, 0);
        check("ll3 stall_cycles", sc3, 3);

        // Branch in the second STALL cycle
        do_reset();
        load_use(); tick(); bubble_ex(); tick();
        ex_branch_taken = 1'b1; #1;
        check("br3 flush", {31'd0, fl3}, 1);
        check("br3 pc_write", {31'd0, pw3}, 1);
        check("br3 bubble", {31'd0, bub3}, 1);
        tick(); ex_branch_taken = 1'b0; #1;
        check("br3 next stall_active", {31'd0, sa3}, 0);
        check("br3 next pc_write", {31'd0, pw3}, 1);
        check("br3 stall_cycles", sc3, 2);

        // Branch in the first STALL cycle aborts before the natural end
        do_reset();
        load_use(); tick(); bubble_ex();
        ex_branch_taken = 1'b1; #1;
        check("br2 flush", {31'd0, fl3}, 1);
        tick(); ex_branch_taken = 1'b0; #1;
        check("br2 next stall_active", {31'd0, sa3}, 0);
        check("br2 next pc_write", {31'd0, pw3}, 1);
        check("br2 stall_cycles", sc3, 1);

        // Reset while in STALL
        do_reset();
        load_use(); tick(); bubble_ex(); #1;
        check("rs stall_active before", {31'd0, sa3}, 1);
        rst_n = 1'b0; tick(); #1;
        check("rs stall_active", {31'd0, sa3}, 0);
        check("rs pc_write", {31'd0, pw3}, 1);
        check("rs stall_cycles", sc3, 0);
        rst_n = 1'b1;

        // add x1 in EX, sub x2,x1,x1 in IF/ID advancing through the pipe
        do_reset();
        ifid_instr = sub211; idex_reg_write = 1'b1; idex_rd = 5'd1; #1;
        check("raw c1 pc_write", {31'd0, pw1}, {31'd0, FWD});
        check("raw c1 fwd_a", {30'd0, fa1}, 0);
        tick();
        idex_reg_write = 1'b0; idex_rd = 5'd0; idex_rs1 = 5'd1;
        exmem_reg_write = 1'b1; exmem_rd = 5'd1; #1;
        check("raw c2 pc_write", {31'd0, pw1}, {31'd0, FWD});
        check("raw c2 fwd_a", {30'd0, fa1}, {30'd0, f10});
        tick();
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; memwb_reg_write = 1'b1; memwb_rd = 5'd1; #1;
        check("raw c3 pc_write", {31'd0, pw1}, 1);
        check("raw stall_cycles", {29'd0, sc1}, FWD ? 32'd0 : 32'd2);

        // Saturation of the 3-bit counter under a held hazard
        do_reset();
        load_use();
        repeat (9) tick();
        #1;
        check("sat stall_cycles", {29'd0, sc1}, 7);
        check("sat pc_write", {31'd0, pw1}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
